lcd_ahb_seq_master: RTL



---
 rtl/lcd_ahb_seq_master.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_ahb_seq_master.sv
// ---------------------------------------------------------------------------
// lcd_ahb_seq_master
//
// AHB-lite initiator that brings up the LCD driver configuration slave from a
// hardware command stream, with no CPU in the loop. After start_i it writes
// the prescaler register and enables the PHY through LCD_CTRL. For each
// instruction taken from the command stream it then polls LCD_CTRL until
// phy_ready (bit 1) is set, and writes the instruction to LCD_INSTR.
// Transfers that end with an AHB ERROR are reissued until MAX_RETRY ERRORs
// have been seen for the same transfer, at which point the sequencer faults.
//
// Optional feature (macro LCD_SEQ_POLL_TIMEOUT_EN): bound the number of
// not-ready LCD_CTRL polls per instruction to POLL_TIMEOUT, then fault.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            start pulse (honoured in IDLE, DONE and FAULT only)
//   cmd_valid_i        command stream: instruction available
//   cmd_instr_i        command stream: instruction word
//   cmd_last_i         command stream: final instruction of the sequence
//   cmd_ready_o        command stream: instruction accepted this cycle
//   haddr_o, htrans_o,
//   hwrite_o, hwdata_o AHB-lite initiator request (IDLE / NONSEQ only)
//   hrdata_i, hready_i,
//   hresp_i            AHB-lite response
//   busy_o             sequence in progress
//   done_o             one-cycle pulse on successful completion
//   fault_o            sticky fault flag, cleared by the next accepted start
// ---------------------------------------------------------------------------

`ifndef LCD_CTRL_OFFSET
`define LCD_CTRL_OFFSET 12'h000
`endif
`ifndef LCD_INSTR_OFFSET
`define LCD_INSTR_OFFSET 12'h004
`endif
`ifndef PRESCALER_OFFSET
`define PRESCALER_OFFSET 12'h008
`endif

module lcd_ahb_seq_master #(
  parameter int INSTR_WIDTH     = 10,
  parameter int PRESCALER_WIDTH = 16,
  parameter int PRESCALER_INIT  = 10,
  parameter int MAX_RETRY       = 3,
  parameter int POLL_TIMEOUT    = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   cmd_valid_i,
  input  logic [INSTR_WIDTH-1:0] cmd_instr_i,
  input  logic                   cmd_last_i,
  output logic                   cmd_ready_o,
  output logic [11:0]            haddr_o,
  output logic [1:0]             htrans_o,
  output logic                   hwrite_o,
  output logic [31:0]            hwdata_o,
  input  logic [31:0]            hrdata_i,
  input  logic                   hready_i,
  input  logic                   hresp_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fault_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_PRESC, S_W_CTRL, S_GET_CMD, S_POLL, S_W_INSTR, S_DONE, S_FAULT
  } state_t;

  typedef enum logic {PH_ADDR, PH_DATA} phase_t;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [11:0] ADDR_CTRL     = 12'(`LCD_CTRL_OFFSET);
  localparam logic [11:0] ADDR_INSTR    = 12'(`LCD_INSTR_OFFSET);
  localparam logic [11:0] ADDR_PRESC    = 12'(`PRESCALER_OFFSET);
  localparam logic [PRESCALER_WIDTH-1:0] PRESC_FIELD = PRESCALER_WIDTH'(PRESCALER_INIT);
  localparam logic [31:0] PRESC_DATA    = 32'(PRESC_FIELD);
  localparam logic [3:0]  RETRY_LIMIT   = 4'(MAX_RETRY);

  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_max_retry
    $error("lcd_ahb_seq_master: MAX_RETRY must be in 1..15");
  end

  state_t                 state_q;
  phase_t                 phase_q;
  logic [3:0]             retry_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   last_q;

`ifdef LCD_SEQ_POLL_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PCW-1:0] POLL_LIMIT = PCW'(POLL_TIMEOUT);
  localparam logic [PCW-1:0] POLL_ONE   = PCW'(1);
  logic [PCW-1:0] poll_cnt_q;
`else
  localparam int unused_poll_timeout = POLL_TIMEOUT;
`endif

  // Only phy_ready is meaningful in LCD_CTRL read data.
  logic unused_rdata;
  assign unused_rdata = ^{hrdata_i[31:2], hrdata_i[0]};

  // Sequencer and transfer engine in one register block. In the transfer
  // states phase_q tracks the single outstanding transfer: the ADDR cycle
  // drives NONSEQ, every following cycle is a DATA cycle with htrans IDLE
  // until hready_i completes it. haddr/hwrite/hwdata are left untouched on an
  // ERROR so the reissue one cycle later is identical. All outputs are
  // registered, so each transition also loads the next transfer's request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_ADDR;
      retry_q     <= '0;
      instr_q     <= '0;
      last_q      <= 1'b0;
      htrans_o    <= HTRANS_IDLE;
      haddr_o     <= '0;
      hwrite_o    <= 1'b0;
      hwdata_o    <= '0;
      cmd_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fault_o     <= 1'b0;
`ifdef LCD_SEQ_POLL_TIMEOUT_EN
      poll_cnt_q  <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start_i) begin
            fault_o  <= 1'b0;
            busy_o   <= 1'b1;
            retry_q  <= '0;
            state_q  <= S_W_PRESC;
            phase_q  <= PH_ADDR;
            htrans_o <= HTRANS_NONSEQ;
            haddr_o  <= ADDR_PRESC;
            hwrite_o <= 1'b1;
            hwdata_o <= PRESC_DATA;
          end
        end

        // Ready is raised only once an instruction is offered, and dropped
        // after that single accepting cycle.
        S_GET_CMD: begin
          if (!cmd_ready_o) begin
            cmd_ready_o <= cmd_valid_i;
          end else begin
            cmd_ready_o <= 1'b0;
            if (cmd_valid_i) begin
              instr_q  <= cmd_instr_i;
              last_q   <= cmd_last_i;
              retry_q  <= '0;
              state_q  <= S_POLL;
              phase_q  <= PH_ADDR;
              htrans_o <= HTRANS_NONSEQ;
              haddr_o  <= ADDR_CTRL;
              hwrite_o <= 1'b0;
              hwdata_o <= '0;
`ifdef LCD_SEQ_POLL_TIMEOUT_EN
              poll_cnt_q <= '0;
`endif
            end
          end
        end

        S_W_PRESC, S_W_CTRL, S_POLL, S_W_INSTR: begin
          if (phase_q == PH_ADDR) begin
            htrans_o <= HTRANS_IDLE;
            phase_q  <= PH_DATA;
          end else if (hready_i) begin
            if (hresp_i) begin
              if (retry_q + 4'd1 == RETRY_LIMIT) begin
                state_q <= S_FAULT;
                fault_o <= 1'b1;
                busy_o  <= 1'b0;
              end else begin
                retry_q  <= retry_q + 4'd1;
                htrans_o <= HTRANS_NONSEQ;
                phase_q  <= PH_ADDR;
              end
            end else begin
              retry_q <= '0;
              case (state_q)
                S_W_PRESC: begin
                  state_q  <= S_W_CTRL;
                  phase_q  <= PH_ADDR;
                  htrans_o <= HTRANS_NONSEQ;
                  haddr_o  <= ADDR_CTRL;
                  hwrite_o <= 1'b1;
                  hwdata_o <= 32'h1;
                end
                S_W_CTRL: begin
                  state_q <= S_GET_CMD;
                end
                S_POLL: begin
                  if (hrdata_i[1]) begin
                    state_q  <= S_W_INSTR;
                    phase_q  <= PH_ADDR;
                    htrans_o <= HTRANS_NONSEQ;
                    haddr_o  <= ADDR_INSTR;
                    hwrite_o <= 1'b1;
                    hwdata_o <= 32'(instr_q);
                  end else begin
`ifdef LCD_SEQ_POLL_TIMEOUT_EN
                    if (poll_cnt_q + POLL_ONE == POLL_LIMIT) begin
                      state_q <= S_FAULT;
                      fault_o <= 1'b1;
                      busy_o  <= 1'b0;
                    end else begin
                      poll_cnt_q <= poll_cnt_q + POLL_ONE;
                      htrans_o   <= HTRANS_NONSEQ;
                      phase_q    <= PH_ADDR;
                    end
`else
                    htrans_o <= HTRANS_NONSEQ;
                    phase_q  <= PH_ADDR;
`endif
                  end
                end
                S_W_INSTR: begin
                  if (last_q) begin
                    state_q <= S_DONE;
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                  end else begin
                    state_q <= S_GET_CMD;
                  end
                end
                default: ;
              endcase
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
